// File: rtl/window_loader.sv
// 3x3 pixel window loader: fetches a full 9-pixel window or shifts the window
// one step (right/left/up) and fetches only the 3 newly exposed pixels.
module window_loader (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [11:0] width,
    input  logic [7:0]  addr_r,
    input  logic [1:0]  direction,
    input  logic        start_i_read,
    input  logic        start_9_read,
    output logic [7:0]  mem_addr,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic [71:0] window,
    output logic        busy,
    output logic        load_done,
    output logic [1:0]  dbg_state
);

    // Memory handshake: mem_addr is valid while mem_re is high and stays put
    // until mem_rvalid is sampled high; that cycle captures mem_rdata.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [1:0] M_FULL  = 2'b00;
    localparam logic [1:0] M_RIGHT = 2'b01;
    localparam logic [1:0] M_LEFT  = 2'b10;
    localparam logic [1:0] M_UP    = 2'b11;

    state_t      r_state;
    logic [1:0]  r_mode;
    logic [7:0]  r_anchor;
    logic [7:0]  r_width;
    logic [3:0]  r_idx;
    logic [7:0]  r_mem_addr;
    logic        r_mem_re;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_pix [0:8];

    logic        w_start;
    logic [1:0]  w_mode;
    logic [3:0]  w_last;
    logic [3:0]  w_slot;
    logic [7:0]  w_first_addr;
    logic [7:0]  w_next_addr;
    logic        w_unused;

    function automatic logic [1:0] row_of(input logic [1:0] mode, input logic [3:0] idx);
        case (mode)
            M_FULL:          row_of = (idx < 4'd3) ? 2'd0 : (idx < 4'd6) ? 2'd1 : 2'd2;
            M_RIGHT, M_LEFT: row_of = idx[1:0];
            default:         row_of = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] col_of(input logic [1:0] mode, input logic [3:0] idx);
        case (mode)
            M_FULL:  col_of = (idx < 4'd3) ? idx[1:0] :
                              (idx < 4'd6) ? 2'(idx - 4'd3) : 2'(idx - 4'd6);
            M_RIGHT: col_of = 2'd2;
            M_LEFT:  col_of = 2'd0;
            default: col_of = idx[1:0];
        endcase
    endfunction

    // anchor + r*stride + c, wrapping at 256
    function automatic logic [7:0] pix_addr(input logic [7:0] anchor, input logic [7:0] w,
                                            input logic [1:0] mode, input logic [3:0] idx);
        logic [1:0] r;
        logic [1:0] c;
        logic [7:0] off;
        r   = row_of(mode, idx);
        c   = col_of(mode, idx);
        off = (r == 2'd0) ? 8'd0 : (r == 2'd1) ? w : {w[6:0], 1'b0};
        pix_addr = anchor + off + {6'd0, c};
    endfunction

    function automatic logic [3:0] slot_of(input logic [1:0] mode, input logic [3:0] idx);
        logic [3:0] r;
        logic [3:0] c;
        r = {2'b00, row_of(mode, idx)};
        c = {2'b00, col_of(mode, idx)};
        slot_of = r + r + r + c;
    endfunction

    always_comb begin
        w_start      = start_i_read | start_9_read;
        w_mode       = start_i_read ? M_FULL : direction;
        w_last       = (r_mode == M_FULL) ? 4'd8 : 4'd2;
        w_slot       = slot_of(r_mode, r_idx);
        w_first_addr = pix_addr(addr_r, width[7:0], w_mode, 4'd0);
        w_next_addr  = pix_addr(r_anchor, r_width, r_mode, r_idx + 4'd1);
        w_unused     = ^width[11:8];
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= S_IDLE;
            r_mode     <= M_FULL;
            r_anchor   <= 8'd0;
            r_width    <= 8'd0;
            r_idx      <= 4'd0;
            r_mem_addr <= 8'd0;
            r_mem_re   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < 9; i++) r_pix[i] <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_READ;
                        r_mode     <= w_mode;
                        r_anchor   <= addr_r;
                        r_width    <= width[7:0];
                        r_idx      <= 4'd0;
                        r_mem_addr <= w_first_addr;
                        r_mem_re   <= 1'b1;
                        r_busy     <= 1'b1;
                        // The shift frees the edge that the 3 reads refill
                        case (w_mode)
                            M_RIGHT: begin
                                r_pix[0] <= r_pix[1]; r_pix[1] <= r_pix[2];
                                r_pix[3] <= r_pix[4]; r_pix[4] <= r_pix[5];
                                r_pix[6] <= r_pix[7]; r_pix[7] <= r_pix[8];
                            end
                            M_LEFT: begin
                                r_pix[2] <= r_pix[1]; r_pix[1] <= r_pix[0];
                                r_pix[5] <= r_pix[4]; r_pix[4] <= r_pix[3];
                                r_pix[8] <= r_pix[7]; r_pix[7] <= r_pix[6];
                            end
                            M_UP: begin
                                r_pix[0] <= r_pix[3]; r_pix[1] <= r_pix[4]; r_pix[2] <= r_pix[5];
                                r_pix[3] <= r_pix[6]; r_pix[4] <= r_pix[7]; r_pix[5] <= r_pix[8];
                            end
                            default: ;
                        endcase
                    end
                end
                S_READ: begin
                    if (mem_rvalid) begin
                        r_pix[w_slot] <= mem_rdata;
                        if (r_idx == w_last) begin
                            r_state  <= S_DONE;
                            r_mem_re <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_idx      <= r_idx + 4'd1;
                            r_mem_addr <= w_next_addr;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < 9; g++) begin : g_win
        assign window[8*g +: 8] = r_pix[g];
    end

    assign mem_addr  = r_mem_addr;
    assign mem_re    = r_mem_re;
    assign busy      = r_busy;
    assign load_done = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_window_loader.sv
// Bench for window_loader: directed window sequences, wrap-around, delayed
// memory, mid-load reset, then randomized loads against a 3x3 array model.
module tb_window_loader;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [11:0] width;
    logic [7:0]  addr_r;
    logic [1:0]  direction;
    logic        start_i_read;
    logic        start_9_read;
    logic [7:0]  mem_addr;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic [71:0] window;
    logic        busy;
    logic        load_done;
    logic [1:0]  dbg_state;

    window_loader dut (
        .clk(clk), .n_reset(n_reset), .width(width), .addr_r(addr_r),
        .direction(direction), .start_i_read(start_i_read), .start_9_read(start_9_read),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .window(window), .busy(busy), .load_done(load_done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_err    = 0;
    int         wait_n   = 0;
    logic [7:0] key      = 8'd0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] mwin [0:2][0:2];

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] pack_model();
        logic [71:0] p;
        p = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[8*(3*r+c) +: 8] = mwin[r][c];
        return p;
    endfunction

    // Memory: returns addr ^ key after wait_n idle cycles; junk outside reads
    int         cnt = 0;
    bit         prev_wait = 0;
    logic [7:0] prev_addr = 8'd0;
    always @(negedge clk) begin
        if (!n_reset) begin
            cnt = 0; prev_wait = 0; mem_rvalid = 1'b0;
        end else if (mem_re) begin
            if (prev_wait) check("addr_hold", mem_addr, prev_addr);
            mem_rvalid = (cnt >= wait_n);
            mem_rdata  = mem_addr ^ key;
            if (mem_rvalid) begin
                got_q.push_back(mem_addr); cnt = 0; prev_wait = 0;
            end else begin
                cnt++; prev_wait = 1; prev_addr = mem_addr;
            end
        end else begin
            cnt = 0; prev_wait = 0;
            mem_rvalid = ($urandom_range(0, 3) == 0);
            mem_rdata  = 8'($urandom);
        end
        if (load_done) done_cnt++;
    end

    // Called at a negedge with the DUT idle; returns at the negedge after load_done.
    task automatic run_load(input bit s_i, input bit s_9, input logic [1:0] dir,
                            input logic [7:0] anch, input logic [11:0] w, input bit spam);
        logic [7:0] nw [0:2][0:2];
        logic [7:0] a;
        logic [71:0] win_at_done;
        int cyc;
        bit seen;
        int nr;
        exp_q.delete();
        got_q.delete();
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) nw[r][c] = mwin[r][c];
        if (s_i || dir == 2'b00) begin
            for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) begin
                a = 8'(int'(anch) + r * int'(w[7:0]) + c);
                exp_q.push_back(a); nw[r][c] = a ^ key;
            end
        end else if (dir == 2'b01) begin
            for (int r = 0; r < 3; r++) begin
                nw[r][0] = mwin[r][1]; nw[r][1] = mwin[r][2];
                a = 8'(int'(anch) + r * int'(w[7:0]) + 2);
                exp_q.push_back(a); nw[r][2] = a ^ key;
            end
        end else if (dir == 2'b10) begin
            for (int r = 0; r < 3; r++) begin
                nw[r][2] = mwin[r][1]; nw[r][1] = mwin[r][0];
                a = 8'(int'(anch) + r * int'(w[7:0]));
                exp_q.push_back(a); nw[r][0] = a ^ key;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                nw[0][c] = mwin[1][c]; nw[1][c] = mwin[2][c];
                a = 8'(int'(anch) + 2 * int'(w[7:0]) + c);
                exp_q.push_back(a); nw[2][c] = a ^ key;
            end
        end
        nr = exp_q.size();
        width = w; addr_r = anch; direction = dir;
        start_i_read = s_i; start_9_read = s_9;
        @(negedge clk);
        start_i_read = 1'b0; start_9_read = 1'b0;
        check("busy_after_start", busy, 1'b1);
        cyc = 1; seen = 0;
        while (cyc < 100) begin
            if (load_done) begin seen = 1; break; end
            if (spam) begin
                start_i_read = 1'($urandom_range(0, 1));
                start_9_read = 1'($urandom_range(0, 1));
                addr_r       = 8'($urandom);
                direction    = 2'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start_i_read = 1'b0; start_9_read = 1'b0;
        check("load_done_seen", seen, 1'b1);
        check("latency", cyc, nr * (wait_n + 1) + 1);
        check("busy_in_done", busy, 1'b1);
        check("mem_re_in_done", mem_re, 1'b0);
        check("read_count", got_q.size(), nr);
        for (int i = 0; i < nr && i < got_q.size(); i++) check("read_addr", got_q[i], exp_q[i]);
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mwin[r][c] = nw[r][c];
        check("window", window, pack_model());
        win_at_done = window;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_done_pulse", load_done, 1'b0);
        check("idle_window_hold", window, win_at_done);
    endtask

    initial begin
        int cyc;
        int done_before;
        n_reset = 1'b0; width = 12'd0; addr_r = 8'd0; direction = 2'd0;
        start_i_read = 1'b0; start_9_read = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 8'd0;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mwin[r][c] = 8'd0;
        #3;
        check("rst_mem_re", mem_re, 1'b0);
        check("rst_mem_addr", mem_addr, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_load_done", load_done, 1'b0);
        check("rst_window", window, 72'd0);
        @(negedge clk); @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);

        // Directed window walk with zero-wait memory
        run_load(1'b1, 1'b0, 2'b00, 8'd100, 12'd5, 1'b0);
        check("full_window_literal", window,
              {8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102, 8'd101, 8'd100});
        run_load(1'b0, 1'b1, 2'b01, 8'd101, 12'd5, 1'b0);
        run_load(1'b0, 1'b1, 2'b11, 8'd106, 12'd5, 1'b0);
        run_load(1'b0, 1'b1, 2'b10, 8'd105, 12'd5, 1'b0);
        check("left_window_literal", window,
              {8'd117, 8'd116, 8'd115, 8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105});

        // Address wrap-around
        run_load(1'b1, 1'b0, 2'b00, 8'd250, 12'd5, 1'b0);
        check("wrap_addr4", (got_q.size() > 4) ? got_q[4] : 8'hxx, 8'd0);

        // Slow memory, start spam while busy, both starts at once
        wait_n = 2;
        run_load(1'b1, 1'b0, 2'b00, 8'd37, 12'd5, 1'b1);
        run_load(1'b1, 1'b1, 2'b01, 8'd60, 12'h107, 1'b1);
        run_load(1'b0, 1'b1, 2'b00, 8'd9, 12'd3, 1'b1);
        wait_n = 0;

        // Reset after 4 captures of a full load
        done_before = done_cnt;
        got_q.delete();
        width = 12'd5; addr_r = 8'd20; direction = 2'b00; start_i_read = 1'b1;
        @(negedge clk);
        start_i_read = 1'b0;
        cyc = 0;
        while (got_q.size() < 4 && cyc < 100) begin @(negedge clk); #1; cyc++; end
        check("rst_caps_reached", got_q.size() >= 4, 1'b1);
        @(posedge clk); #2;
        n_reset = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_mem_re", mem_re, 1'b0);
        check("midrst_mem_addr", mem_addr, 8'd0);
        check("midrst_load_done", load_done, 1'b0);
        check("midrst_window", window, 72'd0);
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mwin[r][c] = 8'd0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_done", done_cnt, done_before);
        check("midrst_idle", busy, 1'b0);
        run_load(1'b1, 1'b0, 2'b00, 8'd20, 12'd5, 1'b0);

        // Randomized loads
        for (int k = 0; k < 40; k++) begin
            bit s_i;
            bit s_9;
            wait_n = $urandom_range(0, 3);
            key    = 8'($urandom);
            s_i    = ($urandom_range(0, 3) == 0);
            s_9    = !s_i || ($urandom_range(0, 1) == 1);
            run_load(s_i, s_9, 2'($urandom), 8'($urandom), 12'($urandom),
                     ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
